// File: rtl/led_pwm_scheduler_if.sv
// Host duty-write handshake between badge top-level logic and led_pwm_scheduler.
// The host side is the master; the scheduler side is the slave and drives wr_ready.
interface led_pwm_scheduler_if #(
  parameter int unsigned PWM_BITS = 8
);
  logic                wr_valid;
  logic                wr_ready;
  logic [3:0]          wr_idx;
  logic [PWM_BITS-1:0] wr_duty;

  modport master (
    output wr_valid,
    output wr_idx,
    output wr_duty,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_idx,
    input  wr_duty,
    output wr_ready
  );
endinterface

// File: rtl/led_pwm_scheduler.sv
// Per-LED PWM duty owner for the badge ledc pins: host-written (MANUAL) or chase/bounce sequencer.
// Optional macro GAMMA_EN applies a square-law gamma curve to each duty before PWM compare.
module led_pwm_scheduler #(
  parameter int unsigned NUM_LEDS = 11,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned TICK_DIV = 2000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [3:0]           chase_first,
  input  logic [3:0]           chase_last,
  led_pwm_scheduler_if.slave   wr,
  output logic                 step_pulse,
  output logic [3:0]           chase_pos,
  output logic [NUM_LEDS-1:0]  ledc
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_MANUAL = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int unsigned         DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [PWM_BITS-1:0] DMAX     = '1;
  localparam logic [3:0]          IDX_MAX  = 4'(NUM_LEDS - 1);

  mode_e               mode_cur;
  mode_e               mode_prev;
  dir_e                dir;
  dir_e                dir_nxt;
  logic [3:0]          head;
  logic [3:0]          head_nxt;
  logic [3:0]          first_c;
  logic [3:0]          last_c;
  logic                in_range;
  logic                wr_ready_q;
  logic [DIV_W-1:0]    div_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty     [NUM_LEDS];
  logic [PWM_BITS-1:0] duty_eff [NUM_LEDS];

  assign wr.wr_ready = wr_ready_q;
  assign chase_pos   = head;

  always_comb begin
    mode_cur = mode_e'(mode);
  end

  always_comb begin
    last_c  = (chase_last > IDX_MAX) ? IDX_MAX : chase_last;
    first_c = (chase_first > last_c) ? last_c : chase_first;
  end

`ifdef GAMMA_EN
  function automatic logic [PWM_BITS-1:0] gamma(input logic [PWM_BITS-1:0] d);
    logic [2*PWM_BITS-1:0] sq;
    sq = (2*PWM_BITS)'(d) * (2*PWM_BITS)'(d) + (2*PWM_BITS)'(DMAX);
    return PWM_BITS'(sq >> PWM_BITS);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      duty_eff[i] = gamma(duty[i]);
    end
  end
`else
  always_comb begin
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      duty_eff[i] = duty[i];
    end
  end
`endif

  // Next head/direction for a sequencer step; a collapsed or escaped range pins the head to F.
  always_comb begin
    head_nxt = first_c;
    dir_nxt  = DIR_UP;
    in_range = (head >= first_c) && (head <= last_c);
    if (in_range && (first_c != last_c)) begin
      if (mode_cur == MODE_CHASE) begin
        head_nxt = (head >= last_c) ? first_c : head + 4'd1;
      end else if (dir == DIR_UP) begin
        if (head >= last_c) begin
          head_nxt = head - 4'd1;
          dir_nxt  = DIR_DOWN;
        end else begin
          head_nxt = head + 4'd1;
        end
      end else begin
        if (head <= first_c) begin
          head_nxt = head + 4'd1;
        end else begin
          head_nxt = head - 4'd1;
          dir_nxt  = DIR_DOWN;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_prev  <= MODE_OFF;
      dir        <= DIR_UP;
      head       <= '0;
      wr_ready_q <= 1'b0;
      div_cnt    <= '0;
      step_pulse <= 1'b0;
      pwm_cnt    <= '0;
      ledc       <= '0;
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        duty[i] <= '0;
      end
    end else begin
      mode_prev  <= mode_cur;
      wr_ready_q <= (mode_cur == MODE_MANUAL);
      pwm_cnt    <= pwm_cnt + 1'b1;

      if (mode_cur == MODE_OFF) begin
        div_cnt    <= '0;
        step_pulse <= 1'b0;
      end else if (div_cnt == DIV_LAST) begin
        div_cnt    <= '0;
        step_pulse <= 1'b1;
      end else begin
        div_cnt    <= div_cnt + 1'b1;
        step_pulse <= 1'b0;
      end

      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        ledc[i] <= (duty_eff[i] > pwm_cnt);
      end

      // Priority: mode entry, then sequencer step, then host write.
      if (mode_cur != mode_prev) begin
        case (mode_cur)
          MODE_OFF: begin
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
              duty[i] <= '0;
            end
          end
          MODE_CHASE, MODE_BOUNCE: begin
            head <= first_c;
            dir  <= DIR_UP;
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
              duty[i] <= (4'(i) == first_c) ? DMAX : '0;
            end
          end
          default: ;
        endcase
      end else if (step_pulse && ((mode_cur == MODE_CHASE) || (mode_cur == MODE_BOUNCE))) begin
        head <= head_nxt;
        dir  <= dir_nxt;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
          duty[i] <= (4'(i) == head_nxt) ? DMAX : (duty[i] >> 1);
        end
      end else if (wr.wr_valid && wr_ready_q) begin
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
          if (wr.wr_idx == 4'(i)) begin
            duty[i] <= wr.wr_duty;
          end
        end
      end
    end
  end

endmodule

// File: doc/led_pwm_scheduler.md
Name: led_pwm_scheduler

Overview:
Owns the badge LED column outputs (ledc) and decides who drives each LED's brightness. Holds one PWM duty register per LED and generates PWM from a free-running counter. In MANUAL mode a host port writes the duties. In CHASE or BOUNCE mode an internal step sequencer writes them, moving a lit head with a fading tail. Sits between badge top-level logic and the ledc pins, replacing the free-running chaser.

Parameters:
NUM_LEDS, 11, number of LED outputs driven (ledc width).
PWM_BITS, 8, duty/PWM counter width; full scale DMAX = 2^PWM_BITS-1.
TICK_DIV, 2000000, clk cycles per sequencer step.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
mode  in  2  0=OFF, 1=MANUAL, 2=CHASE, 3=BOUNCE
chase_first  in  4  first LED index of sequencer range
chase_last  in  4  last LED index of sequencer range
wr_valid  in  1  host duty write request
wr_ready  out  1  scheduler accepts host write
wr_idx  in  4  LED index for host write
wr_duty  in  PWM_BITS  duty value for host write
step_pulse  out  1  one-cycle strobe per sequencer step
chase_pos  out  4  current head index
ledc  out  NUM_LEDS  registered LED drive, 1 = lit

Behaviour:
- Reset (async, any time, mid-operation included): ledc=0, step_pulse=0, chase_pos=0, wr_ready=0. Also clears all duties, step counter, PWM counter and dir (dir=up).
- Step divider: counter runs 0..TICK_DIV-1. step_pulse=1 for the single cycle after the counter wraps. In OFF, the counter is held at 0 and step_pulse=0.
- PWM: pwm_cnt (PWM_BITS) increments every clk and wraps. ledc[i] is registered as (duty_eff[i] > pwm_cnt).
  - duty 0: LED never lit.
  - duty DMAX: lit DMAX of every 2^PWM_BITS cycles.
- Latency: duty register updates 1 cycle after an accepted write or step; ledc reflects it 1 cycle later.
- Host port: wr_ready = (mode==MANUAL), registered, so it is valid 1 cycle after the mode change.
  - A write is accepted when wr_valid && wr_ready; duty[wr_idx] <= wr_duty.
  - wr_idx >= NUM_LEDS: write is accepted and discarded.
  - In any other mode wr_ready=0 and writes are ignored.
- Range clamp, recomputed each cycle:
  - L = min(chase_last, NUM_LEDS-1).
  - F = min(chase_first, L).
  - F == L: head stays at F and does not move.
- Mode entry (mode differs from the previous cycle):
  - to OFF: all duties cleared.
  - to CHASE or BOUNCE: all duties cleared, head=F, dir=up, duty[F]=DMAX.
  - to MANUAL: duties retained.
  - A mode entry in the same cycle as step_pulse takes precedence; that step is dropped.
- Step in CHASE:
  - head advances by 1; if head >= L it wraps to F.
  - If head lies outside [F,L] (range changed), next head = F.
- Step in BOUNCE:
  - dir up: head+1; if head >= L then head-1 and dir=down.
  - dir down: head-1; if head <= F then head+1 and dir=up.
  - Outside [F,L]: head=F, dir=up.
- Fade on every step, applied simultaneously with the move:
  - duty[new head] = DMAX.
  - every other duty >>= 1, so the old head becomes DMAX>>1.
- chase_pos = head, registered, same cycle as the duty update.
- MANUAL after CHASE: the sequencer stops; head and duties are frozen until written.

Optional Feature:
GAMMA_EN:
- Defined: duty_eff = (duty*duty + DMAX) >> PWM_BITS, combinational, no extra latency. This gives 0->0, 1->1, 128->64, 255->255 for 8 bits.
- Not defined: duty_eff = duty.

Test Plan:
- TICK_DIV=16: assert rst mid-run with ledc active -> ledc=0, chase_pos=0, wr_ready=0 asynchronously; after release with mode=OFF, step_pulse stays 0.
- MANUAL, write idx=3 duty=64 -> duty updates next cycle; ledc[3] is high exactly 64 of each 256 cycles; a write to idx=12 changes nothing.
- CHASE, F=0, L=5 -> chase_pos goes 0,1,2,3,4,5,0 on consecutive step_pulses. After the first step, duty[1]=255 and duty[0]=127; after the next, duty[0]=63.
- BOUNCE, F=2, L=4 -> chase_pos sequence is 2,3,4,3,2,3; F=L=7 -> chase_pos stays 7.
- mode CHASE -> MANUAL in the same cycle as step_pulse -> no advance; wr_ready=1 next cycle; CHASE-mode writes are ignored.
- GAMMA_EN defined, MANUAL duty=128 -> ledc[i] high 64 of 256 cycles; without the macro, 128 of 256.
